pwm_multi_gen: RTL and testbench

- Multi-channel PWM generator, parametrised successor to the single-output PWM clock divider.
- Runtime-programmable prescaler, period, per-channel duty and edge/center alignment.
- Double-buffered configuration, applied only at period boundaries, so no glitches.
- Sits between the control register block and the motor/LED drive outputs.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_prescaler.sv | 34 +++
 rtl/pwm_multi_gen.sv | 163 ++++++++++++++++
 tb/tb_pwm_multi_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode/direction
// encodings, default widths and the reset image of the active configuration.
package pwm_pkg;

    localparam int CH_DEF    = 4;
    localparam int CNT_W_DEF = 8;
    localparam int PRE_W_DEF = 16;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Active configuration resets to all-zero fields in edge mode
    localparam logic ACT_FILL_RST = 1'b0;
    localparam logic ACT_MODE_RST = MODE_EDGE;

    // Center counting needs a non-zero top; Period=0 degenerates to edge mode
    function automatic logic center_mode(input logic mode, input logic period_nz);
        return (mode == MODE_CENTER) && period_nz;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Programmable tick generator: Tick pulses every Limit+1 enabled clocks,
// counting restarts from zero whenever En is low or Clr is asserted.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             Clk_in,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [PRE_W-1:0] Limit,
    input  logic             Clr,
    output logic             Tick
);

    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0] pre_cnt_r;

    assign Tick = En && (pre_cnt_r == Limit);

    // Prescale counter; the >= guard recovers if Limit ever drops below the count
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            pre_cnt_r <= PRE_ZERO;
        end else if (!En || Clr || (pre_cnt_r >= Limit)) begin
            pre_cnt_r <= PRE_ZERO;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with double-buffered configuration that is
// promoted from shadow to active only on a period boundary (or while idle).
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CH    = CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic              Clk_in,
    input  logic              Rst_n,
    input  logic              En,
    input  logic [PRE_W-1:0]  Prescale,
    input  logic [CNT_W-1:0]  Period,
    input  logic [CH*CNT_W-1:0] Duty,
    input  logic              Mode,
    input  logic              Load,
    output logic [CH-1:0]     Pwm_out,
    output logic              Period_end,
    output logic              Load_ack
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0]    sh_prescale_r, act_prescale_r;
    logic [CNT_W-1:0]    sh_period_r, act_period_r;
    logic [CH*CNT_W-1:0] sh_duty_r, act_duty_r;
    logic                sh_mode_r, act_mode_r;
    logic                pending_r;

    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    dir_e                dir_r, dir_nxt_s;
    logic [CH-1:0]       pwm_out_r, pwm_nxt_s;
    logic                period_end_r, load_ack_r;

    logic                tick_s, center_s, boundary_s, apply_s;

    pwm_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .Clk_in (Clk_in),
        .Rst_n  (Rst_n),
        .En     (En),
        .Limit  (act_prescale_r),
        .Clr    (apply_s),
        .Tick   (tick_s)
    );

    // Boundary detection, config promotion and next counter/direction
    always_comb begin
        center_s  = center_mode(act_mode_r, act_period_r != CNT_ZERO);
        cnt_nxt_s = cnt_r;
        dir_nxt_s = dir_r;
        // Period=1 centered never reaches cnt==1 going down, so it ends at the top
        if (center_s) begin
            if (dir_r == DIR_DOWN) begin
                boundary_s = tick_s && (cnt_r == CNT_ONE);
            end else begin
                boundary_s = tick_s && (act_period_r == CNT_ONE) && (cnt_r == act_period_r);
            end
        end else begin
            boundary_s = tick_s && (cnt_r == act_period_r);
        end
        apply_s = pending_r && (boundary_s || !En);

        if (!En || boundary_s) begin
            cnt_nxt_s = CNT_ZERO;
            dir_nxt_s = DIR_UP;
        end else if (!tick_s) begin
            cnt_nxt_s = cnt_r;
        end else if (!center_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (dir_r == DIR_UP) begin
            if (cnt_r == act_period_r) begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                dir_nxt_s = DIR_DOWN;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end
    end

    // Per-channel compare against the active duty
    always_comb begin
        pwm_nxt_s = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            pwm_nxt_s[i] = En && (cnt_r < act_duty_r[i*CNT_W +: CNT_W]);
        end
    end

    // Period counter and direction
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_r <= CNT_ZERO;
            dir_r <= DIR_UP;
        end else begin
            cnt_r <= cnt_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

    // Shadow capture; a Load on the promotion cycle keeps pending for the next one
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            sh_prescale_r <= {PRE_W{ACT_FILL_RST}};
            sh_period_r   <= {CNT_W{ACT_FILL_RST}};
            sh_duty_r     <= {(CH*CNT_W){ACT_FILL_RST}};
            sh_mode_r     <= ACT_MODE_RST;
            pending_r     <= 1'b0;
        end else if (Load) begin
            sh_prescale_r <= Prescale;
            sh_period_r   <= Period;
            sh_duty_r     <= Duty;
            sh_mode_r     <= Mode;
            pending_r     <= 1'b1;
        end else if (apply_s) begin
            pending_r     <= 1'b0;
        end else begin
            pending_r     <= pending_r;
        end
    end

    // Active configuration, promoted from shadow
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            act_prescale_r <= {PRE_W{ACT_FILL_RST}};
            act_period_r   <= {CNT_W{ACT_FILL_RST}};
            act_duty_r     <= {(CH*CNT_W){ACT_FILL_RST}};
            act_mode_r     <= ACT_MODE_RST;
        end else if (apply_s) begin
            act_prescale_r <= sh_prescale_r;
            act_period_r   <= sh_period_r;
            act_duty_r     <= sh_duty_r;
            act_mode_r     <= sh_mode_r;
        end else begin
            act_prescale_r <= act_prescale_r;
            act_period_r   <= act_period_r;
            act_duty_r     <= act_duty_r;
            act_mode_r     <= act_mode_r;
        end
    end

    // Registered outputs
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            pwm_out_r    <= {CH{1'b0}};
            period_end_r <= 1'b0;
            load_ack_r   <= 1'b0;
        end else begin
            pwm_out_r    <= pwm_nxt_s;
            period_end_r <= boundary_s;
            load_ack_r   <= apply_s;
        end
    end

    assign Pwm_out    = pwm_out_r;
    assign Period_end = period_end_r;
    assign Load_ack   = load_ack_r;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: a clock-level reference model predicts
// each cycle's outputs from period length and position, a monitor compares.
module tb_pwm_multi_gen;

    localparam int CH    = 4;
    localparam int CNT_W = 8;
    localparam int PRE_W = 16;

    logic                Clk_in   = 1'b0;
    logic                Rst_n    = 1'b0;
    logic                En       = 1'b0;
    logic [PRE_W-1:0]    Prescale = '0;
    logic [CNT_W-1:0]    Period   = '0;
    logic [CH*CNT_W-1:0] Duty     = '0;
    logic                Mode     = 1'b0;
    logic                Load     = 1'b0;
    logic [CH-1:0]       Pwm_out;
    logic                Period_end;
    logic                Load_ack;

    pwm_multi_gen #(
        .CH    (CH),
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .Clk_in     (Clk_in),
        .Rst_n      (Rst_n),
        .En         (En),
        .Prescale   (Prescale),
        .Period     (Period),
        .Duty       (Duty),
        .Mode       (Mode),
        .Load       (Load),
        .Pwm_out    (Pwm_out),
        .Period_end (Period_end),
        .Load_ack   (Load_ack)
    );

    always #5 Clk_in = ~Clk_in;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          pe;
        logic          ack;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    // Reference model state: active and shadow configs, pending flag,
    // and the clock position inside the current PWM period.
    int a_pre, a_per, a_mode;
    int a_duty[CH];
    int s_pre, s_per, s_mode;
    int s_duty[CH];
    bit pend;
    int phase;

    function automatic int len_of(input int pre, input int per, input int mode);
        if (mode != 0 && per != 0) return 2 * per * (pre + 1);
        return (per + 1) * (pre + 1);
    endfunction

    // Counter value for a clock position: ramp up, then (centered) ramp down
    function automatic int cnt_of(input int ph, input int pre, input int per, input int mode);
        int k;
        k = ph / (pre + 1);
        if (mode != 0 && per != 0 && k > per) return 2 * per - k;
        return k;
    endfunction

    task automatic model_reset();
        a_pre = 0; a_per = 0; a_mode = 0;
        s_pre = 0; s_per = 0; s_mode = 0;
        for (int i = 0; i < CH; i++) begin
            a_duty[i] = 0;
            s_duty[i] = 0;
        end
        pend  = 1'b0;
        phase = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        exp_t e;
        int   len, c;
        bit   bnd, app;
        e   = '0;
        bnd = 1'b0;
        if (En) begin
            len = len_of(a_pre, a_per, a_mode);
            c   = cnt_of(phase, a_pre, a_per, a_mode);
            for (int i = 0; i < CH; i++) e.pwm[i] = (c < a_duty[i]);
            bnd   = (phase == len - 1);
            e.pe  = bnd;
            phase = bnd ? 0 : phase + 1;
        end else begin
            phase = 0;
        end
        app = pend && (bnd || !En);
        if (app) begin
            a_pre = s_pre; a_per = s_per; a_mode = s_mode;
            for (int i = 0; i < CH; i++) a_duty[i] = s_duty[i];
            phase = 0;
            pend  = 1'b0;
        end
        e.ack = app;
        if (Load) begin
            s_pre  = int'(Prescale);
            s_per  = int'(Period);
            s_mode = int'(Mode);
            for (int i = 0; i < CH; i++) s_duty[i] = int'(Duty[i*CNT_W +: CNT_W]);
            pend = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Model process: predicts the outputs registered at each rising edge
    initial begin
        model_reset();
        forever begin
            @(posedge Clk_in or negedge Rst_n);
            if (!Rst_n) model_reset();
            else        model_step();
        end
    end

    // Monitor process: compares DUT outputs on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk_in);
            cycle++;
            if (Rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({Pwm_out, Period_end, Load_ack} !== {e.pwm, e.pe, e.ack}) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got pwm=%b pe=%b ack=%b, expected pwm=%b pe=%b ack=%b",
                             cycle, Pwm_out, Period_end, Load_ack, e.pwm, e.pe, e.ack);
                end
            end
        end
    end

    task automatic scramble();
        Prescale = PRE_W'($urandom_range(7, 0));
        Period   = CNT_W'($urandom_range(255, 0));
        Duty     = $urandom;
        Mode     = 1'($urandom_range(1, 0));
    endtask

    // Called on a falling edge; holds Load for one clock then garbles the inputs
    task automatic do_load(input int pre, input int per, input int d0, input int d1,
                           input int d2, input int d3, input int mode);
        Prescale = PRE_W'(pre);
        Period   = CNT_W'(per);
        Duty     = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
        Mode     = 1'(mode);
        Load     = 1'b1;
        @(negedge Clk_in);
        Load = 1'b0;
        scramble();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk_in);
    endtask

    task automatic wait_phase(input int target, input string name);
        int n;
        n = 0;
        while (phase != target && n < 400) begin
            @(negedge Clk_in);
            n++;
        end
        if (phase != target) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: phase %0d, expected %0d", name, phase, target);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (Pwm_out !== '0 || Period_end !== 1'b0 || Load_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got pwm=%b pe=%b ack=%b, expected all 0",
                     name, Pwm_out, Period_end, Load_ack);
        end
    endtask

    initial begin
        #3 check_zero("reset_state");
        #20 Rst_n = 1'b1;
        @(negedge Clk_in);

        // Edge, prescale 0, period 9: 3/10, 0, always 1, 5/10
        En = 1'b1;
        do_load(0, 9, 3, 0, 10, 5, 0);
        run(40);
        // Prescaled edge: tick every 4 clocks, 20-clock period
        do_load(3, 4, 2, 4, 5, 1, 0);
        run(60);
        // Center aligned, period 8 clocks
        do_load(0, 4, 2, 1, 4, 5, 1);
        run(40);

        // Mid-period duty change only shows from the next period
        do_load(0, 9, 3, 0, 10, 5, 0);
        run(25);
        wait_phase(4, "mid_period_load");
        do_load(0, 9, 7, 0, 10, 5, 0);
        run(25);

        // Load on the boundary clock itself: deferred to the following boundary
        wait_phase(len_of(a_pre, a_per, a_mode) - 1, "boundary_load");
        do_load(0, 9, 1, 2, 3, 4, 0);
        run(25);

        // Async reset mid-period with a load pending
        wait_phase(3, "reset_setup");
        do_load(2, 6, 6, 6, 6, 6, 1);
        run(1);
        @(posedge Clk_in);
        #2 Rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge Clk_in);
        #2 Rst_n = 1'b1;
        @(negedge Clk_in);
        run(10);

        // Load while disabled applies on the next clock
        En = 1'b0;
        run(2);
        do_load(1, 5, 2, 3, 0, 9, 1);
        run(4);
        En = 1'b1;
        run(30);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(24, 0) == 0) begin
                do_load($urandom_range(3, 0), $urandom_range(12, 0), $urandom_range(14, 0),
                        $urandom_range(14, 0), $urandom_range(14, 0), $urandom_range(14, 0),
                        $urandom_range(1, 0));
            end else begin
                Load = 1'b0;
                scramble();
                En = ($urandom_range(99, 0) != 0);
                @(negedge Clk_in);
            end
        end
        En = 1'b1;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
